// File: rtl/bridge_driver_pkg.sv
// Shared types and constants for the N-leg bridge gate driver.
package bridge_driver_pkg;

    typedef enum logic [2:0] {
        LEG_OFF   = 3'd0,
        LEG_DT_HI = 3'd1,
        LEG_HI    = 3'd2,
        LEG_DT_LO = 3'd3,
        LEG_LO    = 3'd4
    } leg_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } glob_state_t;

    // Shortest dead interval ever inserted, whatever the programmed value.
    localparam int unsigned DT_MIN = 1;

endpackage

// File: rtl/bridge_driver_leg.sv
// One bridge leg: complementary gate FSM with dead-time insertion and minimum on-time
// rejection of short switching requests.
module bridge_leg
    import bridge_driver_pkg::*;
#(
    parameter int DT_W    = 10,
    parameter int MINON_W = 12
) (
    input  logic               i_clock,
    input  logic               i_RESET,
    input  logic               i_run,
    input  logic               i_sigma,
    input  logic [DT_W-1:0]    i_deadtime,
    input  logic [MINON_W-1:0] i_min_on,
    output logic               o_gate_hi,
    output logic               o_gate_lo
);

    leg_state_t         state;
    logic [DT_W-1:0]    dead_cnt;
    logic [MINON_W-1:0] on_cnt;
    logic [DT_W-1:0]    dead_eff;
    logic [DT_W-1:0]    dead_load;

    // A zero dead time still inserts one cycle with both gates off.
    assign dead_eff  = (i_deadtime < DT_W'(DT_MIN)) ? DT_W'(DT_MIN) : i_deadtime;
    assign dead_load = dead_eff - DT_W'(1);

    // NOTE: every state register uses <= so all flops update together from pre-edge values.
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            state     <= LEG_OFF;
            dead_cnt  <= '0;
            on_cnt    <= '0;
            o_gate_hi <= 1'b0;
            o_gate_lo <= 1'b0;
        end else if (!i_run) begin
            state     <= LEG_OFF;
            dead_cnt  <= '0;
            on_cnt    <= '0;
            o_gate_hi <= 1'b0;
            o_gate_lo <= 1'b0;
        end else begin
            case (state)
                LEG_OFF: begin
                    dead_cnt <= dead_load;
                    state    <= i_sigma ? LEG_DT_HI : LEG_DT_LO;
                end
                LEG_DT_HI, LEG_DT_LO: begin
                    // Side is re-evaluated at expiry, not at interval entry.
                    if (dead_cnt == '0) begin
                        on_cnt <= '0;
                        if (i_sigma) begin
                            state     <= LEG_HI;
                            o_gate_hi <= 1'b1;
                        end else begin
                            state     <= LEG_LO;
                            o_gate_lo <= 1'b1;
                        end
                    end else begin
                        dead_cnt <= dead_cnt - DT_W'(1);
                    end
                end
                LEG_HI: begin
                    if (!i_sigma && (on_cnt >= i_min_on)) begin
                        state     <= LEG_DT_LO;
                        o_gate_hi <= 1'b0;
                        dead_cnt  <= dead_load;
                    end else if (on_cnt != {MINON_W{1'b1}}) begin
                        on_cnt <= on_cnt + MINON_W'(1);
                    end
                end
                LEG_LO: begin
                    if (i_sigma && (on_cnt >= i_min_on)) begin
                        state     <= LEG_DT_HI;
                        o_gate_lo <= 1'b0;
                        dead_cnt  <= dead_load;
                    end else if (on_cnt != {MINON_W{1'b1}}) begin
                        on_cnt <= on_cnt + MINON_W'(1);
                    end
                end
                default: begin
                    state     <= LEG_OFF;
                    o_gate_hi <= 1'b0;
                    o_gate_lo <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bridge_driver.sv
// N-leg bridge gate driver: global enable/fault FSM plus one bridge_leg per leg.
// Define BRIDGE_DRIVER_FAULT_SYNC_EN to pass i_fault through a 2-flop synchroniser.
module bridge_driver
    import bridge_driver_pkg::*;
#(
    parameter int N_LEGS  = 2,
    parameter int DT_W    = 10,
    parameter int MINON_W = 12,
    parameter int N_FAULT = 2
) (
    input  logic               i_clock,
    input  logic               i_RESET,
    input  logic               i_enable,
    input  logic [N_LEGS-1:0]  i_sigma,
    input  logic [DT_W-1:0]    i_deadtime,
    input  logic [MINON_W-1:0] i_min_on,
    input  logic [N_FAULT-1:0] i_fault,
    input  logic               i_fault_clear,
    output logic [N_LEGS-1:0]  o_gate_hi,
    output logic [N_LEGS-1:0]  o_gate_lo,
    output logic               o_fault,
    output logic [1:0]         o_state,
    output logic [N_FAULT-1:0] o_fault_src
);

    glob_state_t        state;
    logic               enable_q;
    logic               enable_rise;
    logic               fault_any;
    logic               run;
    logic [N_FAULT-1:0] fault_use;

`ifdef BRIDGE_DRIVER_FAULT_SYNC_EN
    // Fault arrives from the ADC DCO domain.
    logic [N_FAULT-1:0] fault_meta;
    logic [N_FAULT-1:0] fault_sync;

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            fault_meta <= '0;
            fault_sync <= '0;
        end else begin
            fault_meta <= i_fault;
            fault_sync <= fault_meta;
        end
    end

    assign fault_use = fault_sync;
`else
    assign fault_use = i_fault;
`endif

    assign fault_any   = |fault_use;
    assign enable_rise = i_enable & ~enable_q;
    assign run         = (state == ST_RUN);
    assign o_state     = state;

    // NOTE: enable_q resets to 1 so an enable level held through reset is not seen as an edge.
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            enable_q    <= 1'b1;
            state       <= ST_IDLE;
            o_fault     <= 1'b0;
            o_fault_src <= '0;
        end else begin
            enable_q <= i_enable;
            if (fault_any) begin
                state   <= ST_FAULT;
                o_fault <= 1'b1;
                if (state != ST_FAULT) begin
                    o_fault_src <= fault_use;
                end
            end else begin
                case (state)
                    ST_IDLE:  if (enable_rise) state <= ST_RUN;
                    ST_RUN:   if (!i_enable) state <= ST_IDLE;
                    ST_FAULT: begin
                        // Always back to IDLE; RUN needs a fresh enable edge.
                        if (i_fault_clear) begin
                            state   <= ST_IDLE;
                            o_fault <= 1'b0;
                        end
                    end
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < N_LEGS; g++) begin : g_leg
        bridge_leg #(
            .DT_W    (DT_W),
            .MINON_W (MINON_W)
        ) u_leg (
            .i_clock    (i_clock),
            .i_RESET    (i_RESET),
            .i_run      (run),
            .i_sigma    (i_sigma[g]),
            .i_deadtime (i_deadtime),
            .i_min_on   (i_min_on),
            .o_gate_hi  (o_gate_hi[g]),
            .o_gate_lo  (o_gate_lo[g])
        );
    end

    gate_overlap_a: assert property (@(posedge i_clock) disable iff (!i_RESET)
        (o_gate_hi & o_gate_lo) == '0);

endmodule

// File: tb/tb_bridge_driver.sv
// Directed bench for bridge_driver with four legs: dead time, min on-time, fault latch, reset.
module tb_bridge_driver;

    localparam int N_LEGS  = 4;
    localparam int DT_W    = 10;
    localparam int MINON_W = 12;
    localparam int N_FAULT = 2;
`ifdef BRIDGE_DRIVER_FAULT_SYNC_EN
    localparam int FLAT = 3;
`else
    localparam int FLAT = 1;
`endif

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic [N_LEGS-1:0]  sigma;
    logic [DT_W-1:0]    deadtime;
    logic [MINON_W-1:0] min_on;
    logic [N_FAULT-1:0] fault;
    logic               fault_clear;
    logic [N_LEGS-1:0]  gate_hi;
    logic [N_LEGS-1:0]  gate_lo;
    logic               fault_flag;
    logic [1:0]         state;
    logic [N_FAULT-1:0] fault_src;

    int n_vec = 0;
    int n_err = 0;

    bridge_driver #(
        .N_LEGS  (N_LEGS),
        .DT_W    (DT_W),
        .MINON_W (MINON_W),
        .N_FAULT (N_FAULT)
    ) dut (
        .i_clock       (clk),
        .i_RESET       (rst_n),
        .i_enable      (enable),
        .i_sigma       (sigma),
        .i_deadtime    (deadtime),
        .i_min_on      (min_on),
        .i_fault       (fault),
        .i_fault_clear (fault_clear),
        .o_gate_hi     (gate_hi),
        .o_gate_lo     (gate_lo),
        .o_fault       (fault_flag),
        .o_state       (state),
        .o_fault_src   (fault_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_gates(input string tag, input logic [3:0] hi, input logic [3:0] lo);
        check({tag, "_hi"}, 32'(gate_hi), 32'(hi));
        check({tag, "_lo"}, 32'(gate_lo), 32'(lo));
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        sigma       = '0;
        deadtime    = 10'd5;
        min_on      = '0;
        fault       = '0;
        fault_clear = 1'b0;
        #12;
        check_gates("reset", 4'h0, 4'h0);
        check("reset_state", 32'(state), 32'd0);
        check("reset_fault", 32'(fault_flag), 32'd0);
        check("reset_src", 32'(fault_src), 32'd0);
        rst_n = 1'b1;
        tick(2);
        check("idle", 32'(state), 32'd0);

        // Enable edge with sigma=1, dead time 5.
        sigma  = 4'hF;
        enable = 1'b1;
        tick();
        check("run", 32'(state), 32'd1);
        check_gates("run_e1", 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_gates("start_dt", 4'h0, 4'h0);
        end
        tick();
        check_gates("start_hi", 4'hF, 4'h0);

        // Toggle 1->0 with min_on=0: hi drops at edge k, lo rises at k+5.
        sigma = 4'h0;
        tick();
        check_gates("tog_k", 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_gates("tog_dt", 4'h0, 4'h0);
        end
        tick();
        check_gates("tog_lo", 4'h0, 4'hF);

        // Back to HI, then min_on=20.
        sigma = 4'hF;
        tick();
        min_on = 12'd20;
        tick(5);
        check_gates("mo_hi", 4'hF, 4'h0);
        sigma = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_gates("mo_glitch", 4'hF, 4'h0);
        end
        sigma = 4'hF;
        tick();
        sigma = 4'h0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_gates("mo_hold", 4'hF, 4'h0);
        end
        tick();
        check_gates("mo_accept", 4'h0, 4'h0);

        // Dead time 0 gives a one-cycle gap; the current interval still uses 5.
        deadtime = 10'd0;
        min_on   = 12'd0;
        tick(5);
        check_gates("dt0_lo", 4'h0, 4'hF);
        sigma = 4'hF;
        tick();
        check_gates("dt0_gap1", 4'h0, 4'h0);
        tick();
        check_gates("dt0_hi", 4'hF, 4'h0);
        sigma = 4'h0;
        tick();
        check_gates("dt0_gap2", 4'h0, 4'h0);
        tick();
        check_gates("dt0_lo2", 4'h0, 4'hF);

        // Disable: IDLE at next edge, gates off one edge later.
        enable = 1'b0;
        tick();
        check("dis_state", 32'(state), 32'd0);
        check_gates("dis_e1", 4'h0, 4'hF);
        tick();
        check_gates("dis_e2", 4'h0, 4'h0);

        // Re-enable, enter DT_HI, then fault 2'b10.
        deadtime = 10'd5;
        sigma    = 4'hF;
        enable   = 1'b1;
        tick();
        check("reen_state", 32'(state), 32'd1);
        tick();
        fault = 2'b10;
        if (FLAT > 1) tick(FLAT - 1);
        check("flt_pre", 32'(fault_flag), 32'd0);
        tick();
        check("flt_flag", 32'(fault_flag), 32'd1);
        check("flt_state", 32'(state), 32'd2);
        check("flt_src", 32'(fault_src), 32'h2);
        tick();
        check_gates("flt_gates", 4'h0, 4'h0);

        // Clear while fault still present is ignored.
        fault_clear = 1'b1;
        tick();
        check("clr_held_state", 32'(state), 32'd2);
        check("clr_held_flag", 32'(fault_flag), 32'd1);
        check("clr_held_src", 32'(fault_src), 32'h2);
        fault = 2'b00;
        if (FLAT > 1) tick(FLAT - 1);
        tick();
        check("clr_state", 32'(state), 32'd0);
        check("clr_flag", 32'(fault_flag), 32'd0);
        fault_clear = 1'b0;
        tick(3);
        check("clr_no_run", 32'(state), 32'd0);
        check_gates("clr_gates", 4'h0, 4'h0);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        check("clr_rerun", 32'(state), 32'd1);

        // Async reset mid-HI, enable held high across release.
        tick(6);
        check_gates("ar_hi", 4'hF, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_gates("ar_async", 4'h0, 4'h0);
        check("ar_state", 32'(state), 32'd0);
        check("ar_fault", 32'(fault_flag), 32'd0);
        #2;
        rst_n = 1'b1;
        tick(3);
        check("ar_idle", 32'(state), 32'd0);
        check_gates("ar_gates", 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
